// File: rtl/lcd_pkg.sv
// Shared LCD pixel types and constants used by the pixel FIFO and lcdPixelWriter users.
package lcd_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

   // Default divider from system clock to the LCD pixel clock (clock_adj domain).
   localparam int unsigned LCD_PIX_CLK_DIV = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lcd_pixel_ram.sv
// Simple dual-port pixel RAM: one write port, one synchronous read port with read enable.
module lcd_pixel_ram
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 512
) (
   input  logic                     clock,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  rgb_t                     wr_data_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output rgb_t                     rd_data_o
);

   rgb_t mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/lcd_pixel_fifo.sv
// First-word-fall-through pixel FIFO feeding lcdPixelWriter on the pixel clock.
// Optional feature: define LCD_FIFO_STATS_EN to add the saturating underrun_count output.
module lcd_pixel_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned ALMOST_FULL = DEPTH - 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   wr_valid,
   input  logic [23:0]            wr_data,
   output logic                   wr_ready,
   input  logic                   rgb_request,
   output logic [23:0]            rgb_out,
   output logic                   buffer_empty,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] level
`ifdef LCD_FIFO_STATS_EN
   ,
   output logic [15:0]            underrun_count
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W  = ADDR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(ALMOST_FULL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              head_vld_q, head_vld_d;
   logic              shown_q, shown_d;
   logic              wr_ready_q, wr_ready_d;
   logic              af_q, af_d;
   logic              clr, push, pop, load;
   rgb_t              head_q;

   always_comb begin
      clr        = reset | flush;
      push       = wr_valid & wr_ready_q;
      pop        = rgb_request & head_vld_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      head_vld_d = head_vld_q;
      shown_d    = shown_q;
      load       = 1'b0;
      if (clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         head_vld_d = 1'b0;
         shown_d    = 1'b0;
      end else begin
         wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
         rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
         level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
         // Only entries written before this edge can be read into the head register.
         head_vld_d = level_q > LVL_W'(pop);
         load       = head_vld_d & (pop | ~head_vld_q);
         shown_d    = shown_q | load;
      end
      wr_ready_d = level_d < FULL_LVL;
      af_d       = level_d >= AF_LVL;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         head_vld_q <= 1'b0;
         shown_q    <= 1'b0;
         wr_ready_q <= 1'b1;
         af_q       <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         head_vld_q <= head_vld_d;
         shown_q    <= shown_d;
         wr_ready_q <= wr_ready_d;
         af_q       <= af_d;
      end
   end

   // The RAM read register doubles as the head register.
   lcd_pixel_ram #(.DEPTH(DEPTH)) u_ram (
      .clock     (clock),
      .wr_en_i   (push & ~clr),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data),
      .rd_en_i   (load),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (head_q)
   );

   assign rgb_out      = shown_q ? head_q : RGB_BLACK;
   assign buffer_empty = ~head_vld_q;
   assign wr_ready     = wr_ready_q;
   assign almost_full  = af_q;
   assign level        = level_q;

`ifdef LCD_FIFO_STATS_EN
   logic [15:0] urun_q, urun_d;

   always_comb begin
      urun_d = urun_q;
      if (rgb_request & ~head_vld_q) urun_d = sat_inc16(urun_q);
   end

   always_ff @(posedge clock) begin
      if (reset) urun_q <= '0;
      else       urun_q <= urun_d;
   end

   assign underrun_count = urun_q;
`endif

endmodule
